decode_ctrl_pipe: RTL and testbench

Registered successor to the combinational RV32 control decoder. It decodes the ID-stage instruction into the control bundle and registers that bundle into the ID/EX boundary. It also owns three pipeline-control functions:
- load-use hazard stalls,
- branch/jump flush bubbles,
- a parametrised multi-cycle MUL hold counter.

It sits between the IF/ID register and the EX stage.

---
 rtl/decode_ctrl_pipe.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
`timescale 1ns/1ps
// Registered RV32 control decoder feeding the ID/EX boundary.
// Also handles load-use stalls, flush bubbles and the multi-cycle MUL hold.
module decode_ctrl_pipe #(
    parameter int MUL_CYCLES = 4,
    parameter bit ENABLE_M   = 1'b1,
    parameter int ALUCTR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [31:0]         in_instr,
    output logic                in_ready,
    input  logic                flush,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_alu_src1,
    output logic                ex_alu_src2,
    output logic                ex_pc_src,
    output logic                ex_not_zero,
    output logic                ex_pc_data_ctr,
    output logic                ex_mem_write,
    output logic                ex_mem_read,
    output logic                ex_mem_to_reg,
    output logic [ALUCTR_W-1:0] ex_alu_ctr,
    output logic [2:0]          ex_data_type,
    output logic [4:0]          ex_rd,
    output logic                illegal,
    output logic                mul_busy
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_HOLD = CNT_W'(MUL_CYCLES - 1);

    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [ALUCTR_W-1:0] ALU_ADD   = ALUCTR_W'(0);
    localparam logic [ALUCTR_W-1:0] ALU_SUB   = ALUCTR_W'(1);
    localparam logic [ALUCTR_W-1:0] ALU_AND   = ALUCTR_W'(2);
    localparam logic [ALUCTR_W-1:0] ALU_OR    = ALUCTR_W'(3);
    localparam logic [ALUCTR_W-1:0] ALU_XOR   = ALUCTR_W'(4);
    localparam logic [ALUCTR_W-1:0] ALU_SLT   = ALUCTR_W'(5);
    localparam logic [ALUCTR_W-1:0] ALU_SLTU  = ALUCTR_W'(6);
    localparam logic [ALUCTR_W-1:0] ALU_SRA   = ALUCTR_W'(7);
    localparam logic [ALUCTR_W-1:0] ALU_SRL   = ALUCTR_W'(8);
    localparam logic [ALUCTR_W-1:0] ALU_SLL   = ALUCTR_W'(9);
    localparam logic [ALUCTR_W-1:0] ALU_MUL   = ALUCTR_W'(10);
    localparam logic [ALUCTR_W-1:0] ALU_LUI   = ALUCTR_W'(11);
    localparam logic [ALUCTR_W-1:0] ALU_AUIPC = ALUCTR_W'(12);
    localparam logic [ALUCTR_W-1:0] ALU_JUMP  = ALUCTR_W'(13);

    localparam logic [2:0] DT_RIL    = 3'd0;
    localparam logic [2:0] DT_STORE  = 3'd1;
    localparam logic [2:0] DT_BRANCH = 3'd2;
    localparam logic [2:0] DT_JAL    = 3'd4;
    localparam logic [2:0] DT_UPPER  = 3'd5;
    localparam logic [2:0] DT_SHIFT  = 3'd6;

    typedef struct packed {
        logic                regWrite;
        logic                aluSrc1;
        logic                aluSrc2;
        logic                pcSrc;
        logic                notZero;
        logic                pcDataCtr;
        logic                memWrite;
        logic                memRead;
        logic                memToReg;
        logic [ALUCTR_W-1:0] aluCtr;
        logic [2:0]          dataType;
        logic [4:0]          rd;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    ctrl_t      dec;
    logic       decErr;
    logic       useRs1;
    logic       useRs2;
    logic       isMul;

    ctrl_t      exCtrlQ;
    logic       exValidQ;
    logic       illegalQ;
    logic       mulBusyQ;
    logic [CNT_W-1:0] mulCnt;

    always_comb begin
        // NOTE: every decode output gets a default first so no path infers a latch.
        dec    = '0;
        decErr = 1'b0;
        useRs1 = 1'b0;
        useRs2 = 1'b0;
        isMul  = 1'b0;
        case (opcode)
            OP_REG: begin
                useRs1       = 1'b1;
                useRs2       = 1'b1;
                dec.regWrite = 1'b1;
                dec.rd       = rd;
                case (funct7)
                    7'h00: begin
                        case (funct3)
                            3'd0:    dec.aluCtr = ALU_ADD;
                            3'd1:    dec.aluCtr = ALU_SLL;
                            3'd2:    dec.aluCtr = ALU_SLT;
                            3'd3:    dec.aluCtr = ALU_SLTU;
                            3'd4:    dec.aluCtr = ALU_XOR;
                            3'd5:    dec.aluCtr = ALU_SRL;
                            3'd6:    dec.aluCtr = ALU_OR;
                            default: dec.aluCtr = ALU_AND;
                        endcase
                    end
                    7'h20: begin
                        if (funct3 == 3'd0)      dec.aluCtr = ALU_SUB;
                        else if (funct3 == 3'd5) dec.aluCtr = ALU_SRA;
                        else                     decErr     = 1'b1;
                    end
                    7'h01: begin
                        if (ENABLE_M && funct3 == 3'd0) begin
                            dec.aluCtr = ALU_MUL;
                            isMul      = 1'b1;
                        end else begin
                            decErr = 1'b1;
                        end
                    end
                    default: decErr = 1'b1;
                endcase
            end
            OP_IMM: begin
                useRs1       = 1'b1;
                dec.regWrite = 1'b1;
                dec.aluSrc2  = 1'b1;
                dec.rd       = rd;
                case (funct3)
                    3'd0: dec.aluCtr = ALU_ADD;
                    3'd2: dec.aluCtr = ALU_SLT;
                    3'd3: dec.aluCtr = ALU_SLTU;
                    3'd4: dec.aluCtr = ALU_XOR;
                    3'd6: dec.aluCtr = ALU_OR;
                    3'd7: dec.aluCtr = ALU_AND;
                    3'd1: begin
                        dec.dataType = DT_SHIFT;
                        if (funct7 == 7'h00) dec.aluCtr = ALU_SLL;
                        else                 decErr     = 1'b1;
                    end
                    default: begin
                        dec.dataType = DT_SHIFT;
                        if (funct7 == 7'h00)      dec.aluCtr = ALU_SRL;
                        else if (funct7 == 7'h20) dec.aluCtr = ALU_SRA;
                        else                      decErr     = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                useRs1       = 1'b1;
                dec.regWrite = 1'b1;
                dec.aluSrc2  = 1'b1;
                dec.memRead  = 1'b1;
                dec.memToReg = 1'b1;
                dec.aluCtr   = ALU_ADD;
                dec.rd       = rd;
                decErr       = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OP_STORE: begin
                useRs1       = 1'b1;
                useRs2       = 1'b1;
                dec.aluSrc2  = 1'b1;
                dec.memWrite = 1'b1;
                dec.aluCtr   = ALU_ADD;
                dec.dataType = DT_STORE;
                decErr       = (funct3 > 3'd2);
            end
            OP_BRANCH: begin
                useRs1       = 1'b1;
                useRs2       = 1'b1;
                dec.pcSrc    = 1'b1;
                dec.dataType = DT_BRANCH;
                // The ALU result is tested against zero; notZero picks the sense.
                case (funct3)
                    3'd0: begin dec.aluCtr = ALU_SUB;  dec.notZero = 1'b0; end
                    3'd1: begin dec.aluCtr = ALU_SUB;  dec.notZero = 1'b1; end
                    3'd4: begin dec.aluCtr = ALU_SLT;  dec.notZero = 1'b1; end
                    3'd5: begin dec.aluCtr = ALU_SLT;  dec.notZero = 1'b0; end
                    3'd6: begin dec.aluCtr = ALU_SLTU; dec.notZero = 1'b1; end
                    3'd7: begin dec.aluCtr = ALU_SLTU; dec.notZero = 1'b0; end
                    default: decErr = 1'b1;
                endcase
            end
            OP_LUI: begin
                dec.regWrite = 1'b1;
                dec.aluSrc2  = 1'b1;
                dec.aluCtr   = ALU_LUI;
                dec.dataType = DT_UPPER;
                dec.rd       = rd;
            end
            OP_AUIPC: begin
                dec.regWrite = 1'b1;
                dec.aluSrc1  = 1'b1;
                dec.aluSrc2  = 1'b1;
                dec.aluCtr   = ALU_AUIPC;
                dec.dataType = DT_UPPER;
                dec.rd       = rd;
            end
            OP_JAL: begin
                dec.regWrite = 1'b1;
                dec.aluSrc1  = 1'b1;
                dec.pcSrc    = 1'b1;
                dec.aluCtr   = ALU_JUMP;
                dec.dataType = DT_JAL;
                dec.rd       = rd;
            end
            OP_JALR: begin
                useRs1        = 1'b1;
                dec.regWrite  = 1'b1;
                dec.aluSrc1   = 1'b1;
                dec.pcSrc     = 1'b1;
                dec.pcDataCtr = 1'b1;
                dec.aluCtr    = ALU_JUMP;
                dec.dataType  = DT_RIL;
                dec.rd        = rd;
                decErr        = (funct3 != 3'd0);
            end
            default: decErr = 1'b1;
        endcase
    end

    logic holdActive;
    logic loadUse;
    logic accept;

    assign holdActive = (mulCnt != '0);
    assign loadUse    = exValidQ && exCtrlQ.memRead && (exCtrlQ.rd != 5'd0) &&
                        ((useRs1 && rs1 == exCtrlQ.rd) || (useRs2 && rs2 == exCtrlQ.rd));
    assign in_ready   = !flush && !holdActive && !loadUse;
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (!rst_n) begin
            exValidQ <= 1'b0;
            exCtrlQ  <= '0;
            illegalQ <= 1'b0;
            mulBusyQ <= 1'b0;
            mulCnt   <= '0;
        end else if (flush) begin
            exValidQ <= 1'b0;
            exCtrlQ  <= '0;
            illegalQ <= 1'b0;
            mulBusyQ <= 1'b0;
            mulCnt   <= '0;
        end else if (holdActive) begin
            illegalQ <= 1'b0;
            mulBusyQ <= (mulCnt != CNT_W'(1));
            mulCnt   <= mulCnt - CNT_W'(1);
        end else if (accept && !decErr) begin
            exValidQ <= 1'b1;
            exCtrlQ  <= dec;
            illegalQ <= 1'b0;
            mulBusyQ <= isMul && (MUL_HOLD != '0);
            mulCnt   <= isMul ? MUL_HOLD : '0;
        end else begin
            // Stall, idle or illegal accept: all leave a bubble behind.
            exValidQ <= 1'b0;
            exCtrlQ  <= '0;
            illegalQ <= accept && decErr;
            mulBusyQ <= 1'b0;
            mulCnt   <= '0;
        end
    end

    assign ex_valid       = exValidQ;
    assign ex_reg_write   = exCtrlQ.regWrite;
    assign ex_alu_src1    = exCtrlQ.aluSrc1;
    assign ex_alu_src2    = exCtrlQ.aluSrc2;
    assign ex_pc_src      = exCtrlQ.pcSrc;
    assign ex_not_zero    = exCtrlQ.notZero;
    assign ex_pc_data_ctr = exCtrlQ.pcDataCtr;
    assign ex_mem_write   = exCtrlQ.memWrite;
    assign ex_mem_read    = exCtrlQ.memRead;
    assign ex_mem_to_reg  = exCtrlQ.memToReg;
    assign ex_alu_ctr     = exCtrlQ.aluCtr;
    assign ex_data_type   = exCtrlQ.dataType;
    assign ex_rd          = exCtrlQ.rd;
    assign illegal        = illegalQ;
    assign mul_busy       = mulBusyQ;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for decode_ctrl_pipe: a per-cycle instruction-level model
// predicts the ID/EX contents, checked by an independent monitor.
module tb_decode_ctrl_pipe;

    localparam int MUL_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic        flush = 1'b0;
    logic        in_ready, ex_valid, ex_reg_write, ex_alu_src1, ex_alu_src2, ex_pc_src;
    logic        ex_not_zero, ex_pc_data_ctr, ex_mem_write, ex_mem_read, ex_mem_to_reg;
    logic [3:0]  ex_alu_ctr;
    logic [2:0]  ex_data_type;
    logic [4:0]  ex_rd;
    logic        illegal, mul_busy;

    logic        nmValid = 1'b0;
    logic [31:0] nmInstr = 32'h0;
    logic        nmFlush = 1'b0;
    logic        nmReady, nmExValid, nmRegWrite, nmSrc1, nmSrc2, nmPcSrc, nmNotZero;
    logic        nmPcDataCtr, nmMemWrite, nmMemRead, nmMemToReg, nmIllegal, nmMulBusy;
    logic [3:0]  nmAluCtr;
    logic [2:0]  nmDataType;
    logic [4:0]  nmRd;

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.MUL_CYCLES(MUL_CYCLES), .ENABLE_M(1'b1), .ALUCTR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
        .ex_pc_src(ex_pc_src), .ex_not_zero(ex_not_zero), .ex_pc_data_ctr(ex_pc_data_ctr),
        .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_ctr(ex_alu_ctr), .ex_data_type(ex_data_type), .ex_rd(ex_rd),
        .illegal(illegal), .mul_busy(mul_busy)
    );

    decode_ctrl_pipe #(.MUL_CYCLES(MUL_CYCLES), .ENABLE_M(1'b0), .ALUCTR_W(4)) nmDut (
        .clk(clk), .rst_n(rst_n), .in_valid(nmValid), .in_instr(nmInstr),
        .in_ready(nmReady), .flush(nmFlush), .ex_valid(nmExValid),
        .ex_reg_write(nmRegWrite), .ex_alu_src1(nmSrc1), .ex_alu_src2(nmSrc2),
        .ex_pc_src(nmPcSrc), .ex_not_zero(nmNotZero), .ex_pc_data_ctr(nmPcDataCtr),
        .ex_mem_write(nmMemWrite), .ex_mem_read(nmMemRead), .ex_mem_to_reg(nmMemToReg),
        .ex_alu_ctr(nmAluCtr), .ex_data_type(nmDataType), .ex_rd(nmRd),
        .illegal(nmIllegal), .mul_busy(nmMulBusy)
    );

    typedef struct packed {
        logic       valid;
        logic       regWrite, src1, src2, pcSrc, notZero, pcDataCtr, memWrite, memRead, memToReg;
        logic [3:0] aluCtr;
        logic [2:0] dataType;
        logic [4:0] rd;
        logic       illegal;
        logic       busy;
    } obs_t;

    typedef struct {
        obs_t b;
        bit   err;
        bit   u1;
        bit   u2;
        bit   mul;
    } dec_t;

    int   checks = 0;
    int   failures = 0;
    obs_t expQ[$];
    obs_t mState = '0;
    int   mHold = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t actual();
        obs_t a;
        a = {ex_valid, ex_reg_write, ex_alu_src1, ex_alu_src2, ex_pc_src, ex_not_zero,
             ex_pc_data_ctr, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_alu_ctr,
             ex_data_type, ex_rd, illegal, mul_busy};
        return a;
    endfunction

    // Instruction-level reference: classify the word, then fill in its bundle.
    function automatic dec_t refDecode(input logic [31:0] w);
        dec_t d;
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        int rOps[8] = '{0, 9, 5, 6, 4, 8, 3, 2};
        int bOps[8] = '{1, 1, 0, 0, 5, 5, 6, 6};
        bit bNz[8]  = '{0, 1, 0, 0, 1, 0, 1, 0};
        d.b = '0; d.err = 0; d.u1 = 0; d.u2 = 0; d.mul = 0;
        d.b.valid = 1'b1;
        case (op)
            7'h33: begin
                d.u1 = 1; d.u2 = 1; d.b.regWrite = 1; d.b.rd = w[11:7];
                if (f7 == 7'h00) d.b.aluCtr = 4'(rOps[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) d.b.aluCtr = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) d.b.aluCtr = 4'd7;
                else if (f7 == 7'h01 && f3 == 3'd0) begin d.b.aluCtr = 4'd10; d.mul = 1; end
                else d.err = 1;
            end
            7'h13: begin
                d.u1 = 1; d.b.regWrite = 1; d.b.src2 = 1; d.b.rd = w[11:7];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    d.b.dataType = 3'd6;
                    if (f3 == 3'd1 && f7 == 7'h00) d.b.aluCtr = 4'd9;
                    else if (f3 == 3'd5 && f7 == 7'h00) d.b.aluCtr = 4'd8;
                    else if (f3 == 3'd5 && f7 == 7'h20) d.b.aluCtr = 4'd7;
                    else d.err = 1;
                end else d.b.aluCtr = 4'(rOps[f3]);
            end
            7'h03: begin
                d.u1 = 1; d.b.regWrite = 1; d.b.src2 = 1; d.b.memRead = 1; d.b.memToReg = 1;
                d.b.rd = w[11:7];
                d.err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            7'h23: begin
                d.u1 = 1; d.u2 = 1; d.b.src2 = 1; d.b.memWrite = 1; d.b.dataType = 3'd1;
                d.err = (f3 > 3'd2);
            end
            7'h63: begin
                d.u1 = 1; d.u2 = 1; d.b.pcSrc = 1; d.b.dataType = 3'd2;
                d.b.aluCtr = 4'(bOps[f3]); d.b.notZero = bNz[f3];
                d.err = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h37: begin
                d.b.regWrite = 1; d.b.src2 = 1; d.b.aluCtr = 4'd11; d.b.dataType = 3'd5; d.b.rd = w[11:7];
            end
            7'h17: begin
                d.b.regWrite = 1; d.b.src1 = 1; d.b.src2 = 1; d.b.aluCtr = 4'd12;
                d.b.dataType = 3'd5; d.b.rd = w[11:7];
            end
            7'h6F: begin
                d.b.regWrite = 1; d.b.src1 = 1; d.b.pcSrc = 1; d.b.aluCtr = 4'd13;
                d.b.dataType = 3'd4; d.b.rd = w[11:7];
            end
            7'h67: begin
                d.u1 = 1; d.b.regWrite = 1; d.b.src1 = 1; d.b.pcSrc = 1; d.b.pcDataCtr = 1;
                d.b.aluCtr = 4'd13; d.b.rd = w[11:7];
                d.err = (f3 != 3'd0);
            end
            default: d.err = 1;
        endcase
        return d;
    endfunction

    // One cycle: drive inputs, check in_ready, predict the post-edge ID/EX state.
    task automatic step(input logic v, input logic [31:0] w, input logic fl, output logic acc);
        dec_t d;
        obs_t nxt;
        bit   hazard;
        bit   readyExp;
        @(negedge clk);
        in_valid = v; in_instr = w; flush = fl;
        #1;
        d = refDecode(w);
        hazard = mState.valid && mState.memRead && mState.rd != 5'd0 &&
                 ((d.u1 && w[19:15] == mState.rd) || (d.u2 && w[24:20] == mState.rd));
        readyExp = !fl && mHold == 0 && !hazard;
        check("in_ready", in_ready, readyExp);
        nxt = '0;
        if (fl) mHold = 0;
        else if (mHold > 0) begin
            nxt = mState; nxt.illegal = 1'b0; mHold--;
        end else if (!hazard && v) begin
            if (d.err) nxt.illegal = 1'b1;
            else begin
                nxt = d.b;
                if (d.mul) mHold = MUL_CYCLES - 1;
            end
        end
        nxt.busy = (mHold != 0);
        mState = nxt;
        expQ.push_back(nxt);
        acc = v && readyExp;
    endtask

    task automatic sendInstr(input logic [31:0] w, input int flushPct, output int tries);
        logic acc = 1'b0;
        tries = 0;
        while (!acc && tries < 40) begin
            step(1'b1, w, ($urandom_range(99) < flushPct), acc);
            tries++;
        end
        check("accept_within_bound", acc, 1'b1);
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        logic [6:0] f7s[4];
        int sel = $urandom_range(0, 10);
        logic [4:0] rd = 5'($urandom_range(0, 3));
        logic [4:0] r1 = 5'($urandom_range(0, 3));
        logic [4:0] r2 = 5'($urandom_range(0, 3));
        logic [2:0] f3 = 3'($urandom_range(0, 7));
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'($urandom);
        if (sel == 9) return $urandom;
        if (sel == 10) return {7'h01, r2, r1, 3'd0, rd, 7'h33};
        return {f7s[$urandom_range(0, 3)], r2, r1, f3, rd, ops[sel]};
    endfunction

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("ex_bundle", actual(), e);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin : driver
        logic acc;
        int   n;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", actual(), '0);
        rst_n = 1'b1;

        // MUL with the M extension disabled is illegal and leaves a bubble.
        @(negedge clk);
        nmValid = 1'b1; nmInstr = 32'h022081B3;
        @(posedge clk); #1;
        check("nom_mul_illegal", {nmIllegal, nmExValid, nmMulBusy}, 3'b100);
        @(negedge clk);
        nmValid = 1'b0;
        @(posedge clk); #1;
        check("nom_illegal_pulse_end", nmIllegal, 1'b0);

        sendInstr(32'h002081B3, 0, n);
        @(posedge clk); #1;
        check("add_bundle", {ex_valid, ex_reg_write, ex_alu_ctr, ex_data_type, ex_rd},
              {1'b1, 1'b1, 4'd0, 3'd0, 5'd3});

        sendInstr(32'h0000A283, 0, n);
        sendInstr(32'h00228333, 0, n);
        check("load_use_stall_tries", n, 2);
        @(posedge clk); #1;
        check("add_after_stall", {ex_valid, ex_rd}, {1'b1, 5'd6});

        sendInstr(32'h022081B3, 0, n);
        sendInstr(32'h00000013, 0, n);
        check("mul_hold_tries", n, MUL_CYCLES);

        sendInstr(32'h022081B3, 0, n);
        step(1'b0, 32'h0, 1'b0, acc);
        step(1'b0, 32'h0, 1'b1, acc);
        @(posedge clk); #1;
        check("flush_mid_hold", {ex_valid, mul_busy}, 2'b00);
        step(1'b0, 32'h0, 1'b0, acc);
        check("ready_after_flush", in_ready, 1'b1);

        sendInstr(32'hFFFFFFFF, 0, n);
        @(posedge clk); #1;
        check("illegal_word", {illegal, ex_valid}, 2'b10);
        step(1'b0, 32'hFFFFFFFF, 1'b0, acc);
        @(posedge clk); #1;
        check("illegal_not_valid", illegal, 1'b0);

        sendInstr(32'h022081B3, 0, n);
        step(1'b0, 32'h0, 1'b0, acc);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_hold", actual(), '0);
        expQ.delete();
        mState = '0;
        mHold = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sendInstr(32'h002081B3, 0, n);
        @(posedge clk); #1;
        check("add_after_reset", {ex_valid, ex_reg_write, ex_alu_ctr, ex_data_type, ex_rd, mul_busy},
              {1'b1, 1'b1, 4'd0, 3'd0, 5'd3, 1'b0});

        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(9) < 8), randInstr(), ($urandom_range(19) == 0), acc);
        end
        step(1'b0, 32'h0, 1'b0, acc);
        @(posedge clk); #2;
        check("queue_drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
